time_set_ctrl: RTL and testbench

//  User-facing edit sequencer for the time_set field registers. Loads a shadow copy of the

---
 rtl/time_set_pkg.sv | 90 +++++++++
 rtl/tsc_wrap_step.sv | 26 ++
 rtl/time_set_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// time_set_pkg: shared types and constants for the time_set edit sequencer.
//   state_e    - sequencer states (edit per field, commit phases, done)
//   shadow_t   - shadow copy of {mil, hour, min, sec}
//   Field*     - field index constants (0=mil 1=hour 2=min 3=sec)
//   *Min/*Max  - legal ranges for each field, 12h and 24h hour limits
package time_set_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StEMil,
    StEHour,
    StEMin,
    StESec,
    StCSetup,
    StCPulse,
    StCGap,
    StDone
  } state_e;

  typedef struct packed {
    logic [7:0] mil;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } shadow_t;

  localparam logic [1:0] FieldMil  = 2'd0;
  localparam logic [1:0] FieldHour = 2'd1;
  localparam logic [1:0] FieldMin  = 2'd2;
  localparam logic [1:0] FieldSec  = 2'd3;

  localparam logic [7:0] MilMin    = 8'd0;
  localparam logic [7:0] MilMax    = 8'd1;
  localparam logic [7:0] Hour24Min = 8'd0;
  localparam logic [7:0] Hour24Max = 8'd23;
  localparam logic [7:0] Hour12Min = 8'd1;
  localparam logic [7:0] Hour12Max = 8'd12;
  localparam logic [7:0] MsMin     = 8'd0;
  localparam logic [7:0] MsMax     = 8'd59;

  function automatic logic [7:0] get_field(input shadow_t s, input logic [1:0] idx);
    logic [7:0] v;
    unique case (idx)
      FieldMil:  v = s.mil;
      FieldHour: v = s.hour;
      FieldMin:  v = s.min;
      default:   v = s.sec;
    endcase
    return v;
  endfunction

  function automatic shadow_t set_field(input shadow_t s, input logic [1:0] idx,
                                        input logic [7:0] v);
    shadow_t r;
    r = s;
    unique case (idx)
      FieldMil:  r.mil  = v;
      FieldHour: r.hour = v;
      FieldMin:  r.min  = v;
      default:   r.sec  = v;
    endcase
    return r;
  endfunction

  // 24h hour to 12h: midnight becomes 12, afternoon hours drop by 12.
  function automatic logic [7:0] hour_24_to_12(input logic [7:0] h);
    logic [7:0] r;
    if (h == 8'd0) begin
      r = 8'd12;
    end else if (h > 8'd12) begin
      r = h - 8'd12;
    end else begin
      r = h;
    end
    return r;
  endfunction

  // Edit field shown in each edit state; FieldMil outside edit.
  function automatic logic [1:0] state_field(input state_e st);
    logic [1:0] f;
    case (st)
      StEHour: f = FieldHour;
      StEMin:  f = FieldMin;
      StESec:  f = FieldSec;
      default: f = FieldMil;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/tsc_wrap_step.sv
// tsc_wrap_step: combinational wrap-around increment/decrement of one field.
//   val  in  8  current value
//   lo   in  8  minimum legal value
//   hi   in  8  maximum legal value
//   inc  in  1  step up (wraps hi -> lo)
//   dec  in  1  step down (wraps lo -> hi)
//   next out 8  stepped value; unchanged when inc == dec
module tsc_wrap_step (
  input  logic [7:0] val,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] next
);

  always_comb begin
    next = val;
    if (inc && !dec) begin
      next = (val >= hi) ? lo : val + 8'd1;
    end else if (dec && !inc) begin
      next = (val <= lo) ? hi : val - 8'd1;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: edit sequencer for the time_set field registers.
// Loads a sanitised shadow of the live time, lets the operator step each field
// with wrap-around inc/dec, then commits mil, hour, minute, second over a shared
// data bus with one registered load strobe per field.
//   clk, rst_n     clock / async active-low reset
//   cur_time  in   live time {mil, hour, min, sec}
//   btn_*     in   1-cycle button pulses (edit/advance, inc, dec, cancel)
//   time_in   out  commit data bus
//   set_*     out  per-field load strobes (rising edge loads downstream)
//   editing, edit_field, edit_val  out  edit status for display
//   busy, done     out  commit in progress / commit finished pulse
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter logic [7:0]  HOUR_RST = 8'd12,
  parameter int unsigned CMT_GAP  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cur_time,
  input  logic        btn_edit,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_cancel,
  output logic [7:0]  time_in,
  output logic        set_mil,
  output logic        set_hour,
  output logic        set_minute,
  output logic        set_second,
  output logic        editing,
  output logic [1:0]  edit_field,
  output logic [7:0]  edit_val,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] GapLast = 2'(CMT_GAP - 1);

  state_e     state_q, state_d;
  shadow_t    shadow_q, shadow_d;
  logic [1:0] cfield_q, cfield_d;
  logic [1:0] gap_q, gap_d;

  shadow_t    load_val;
  logic [1:0] edit_idx;
  logic [7:0] fld_val, fld_lo, fld_hi, step_val;

  logic [7:0] time_in_d;
  logic       set_mil_d, set_hour_d, set_minute_d, set_second_d;
  logic       editing_d, busy_d, done_d;
  logic [1:0] edit_field_d;
  logic [7:0] edit_val_d;

  // Sanitise the live time; hour legality depends on the already-fixed mil.
  always_comb begin
    load_val.mil  = (cur_time[31:24] > MilMax) ? MilMax : cur_time[31:24];
    load_val.hour = cur_time[23:16];
    if (load_val.mil == MilMax) begin
      if (cur_time[23:16] > Hour24Max) load_val.hour = Hour24Min;
    end else begin
      if (cur_time[23:16] < Hour12Min || cur_time[23:16] > Hour12Max) begin
        load_val.hour = HOUR_RST;
      end
    end
    load_val.min = (cur_time[15:8] > MsMax) ? MsMin : cur_time[15:8];
    load_val.sec = (cur_time[7:0] > MsMax) ? MsMin : cur_time[7:0];
  end

  // Single shared stepper, ranges muxed by the field being edited.
  always_comb begin
    edit_idx = state_field(state_q);
    fld_val  = get_field(shadow_q, edit_idx);
    unique case (edit_idx)
      FieldMil: begin
        fld_lo = MilMin;
        fld_hi = MilMax;
      end
      FieldHour: begin
        fld_lo = (shadow_q.mil == MilMax) ? Hour24Min : Hour12Min;
        fld_hi = (shadow_q.mil == MilMax) ? Hour24Max : Hour12Max;
      end
      default: begin
        fld_lo = MsMin;
        fld_hi = MsMax;
      end
    endcase
  end

  tsc_wrap_step u_step (
    .val  (fld_val),
    .lo   (fld_lo),
    .hi   (fld_hi),
    .inc  (btn_inc),
    .dec  (btn_dec),
    .next (step_val)
  );

  // Next state, shadow and commit sequencer.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cfield_d = cfield_q;
    gap_d    = gap_q;

    case (state_q)
      StIdle: begin
        if (btn_edit) begin
          shadow_d = load_val;
          state_d  = StEMil;
        end
      end

      StEMil, StEHour, StEMin, StESec: begin
        if (btn_cancel) begin
          state_d = StIdle;
        end else if (btn_edit) begin
          case (state_q)
            StEMil:  state_d = StEHour;
            StEHour: state_d = StEMin;
            StEMin:  state_d = StESec;
            default: begin
              state_d  = StCSetup;
              cfield_d = FieldMil;
              gap_d    = '0;
            end
          endcase
        end else if (btn_inc ^ btn_dec) begin
          shadow_d = set_field(shadow_q, edit_idx, step_val);
          // Leaving 24h mode folds the hour into 12h range in the same cycle.
          if (edit_idx == FieldMil && shadow_q.mil == MilMax && step_val == MilMin) begin
            shadow_d.hour = hour_24_to_12(shadow_q.hour);
          end
        end
      end

      StCSetup: state_d = StCPulse;

      StCPulse: begin
        if (CMT_GAP != 0) begin
          state_d = StCGap;
          gap_d   = '0;
        end else if (cfield_q == FieldSec) begin
          state_d = StDone;
        end else begin
          cfield_d = cfield_q + 2'd1;
          state_d  = StCSetup;
        end
      end

      StCGap: begin
        if (gap_q == GapLast) begin
          if (cfield_q == FieldSec) begin
            state_d = StDone;
          end else begin
            cfield_d = cfield_q + 2'd1;
            state_d  = StCSetup;
          end
        end else begin
          gap_d = gap_q + 2'd1;
        end
      end

      StDone:  state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from next state so the registers present them in that state.
  always_comb begin
    editing_d    = (state_d == StEMil) || (state_d == StEHour) ||
                   (state_d == StEMin) || (state_d == StESec);
    busy_d       = (state_d == StCSetup) || (state_d == StCPulse) || (state_d == StCGap);
    done_d       = (state_d == StDone);
    edit_field_d = editing_d ? state_field(state_d) : 2'd0;
    edit_val_d   = editing_d ? get_field(shadow_d, state_field(state_d)) : 8'd0;
    // Bus held through DONE so the last load sees stable data after its edge.
    time_in_d    = (busy_d || done_d) ? get_field(shadow_d, cfield_d) : 8'd0;
    set_mil_d    = (state_d == StCPulse) && (cfield_d == FieldMil);
    set_hour_d   = (state_d == StCPulse) && (cfield_d == FieldHour);
    set_minute_d = (state_d == StCPulse) && (cfield_d == FieldMin);
    set_second_d = (state_d == StCPulse) && (cfield_d == FieldSec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shadow_q   <= '0;
      cfield_q   <= '0;
      gap_q      <= '0;
      time_in    <= '0;
      set_mil    <= 1'b0;
      set_hour   <= 1'b0;
      set_minute <= 1'b0;
      set_second <= 1'b0;
      editing    <= 1'b0;
      edit_field <= '0;
      edit_val   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      cfield_q   <= cfield_d;
      gap_q      <= gap_d;
      time_in    <= time_in_d;
      set_mil    <= set_mil_d;
      set_hour   <= set_hour_d;
      set_minute <= set_minute_d;
      set_second <= set_second_d;
      editing    <= editing_d;
      edit_field <= edit_field_d;
      edit_val   <= edit_val_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with default parameters (HOUR_RST=12, CMT_GAP=1).
module tb_time_set_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] cur_time;
  logic        btn_edit, btn_inc, btn_dec, btn_cancel;
  logic [7:0]  time_in;
  logic        set_mil, set_hour, set_minute, set_second;
  logic        editing;
  logic [1:0]  edit_field;
  logic [7:0]  edit_val;
  logic        busy, done;

  int vectors;
  int miscompares;
  int strobe_edges;

  // Reference shadow: index 0=mil 1=hour 2=min 3=sec; cf = field being edited.
  int m_f[4];
  int cf;

  time_set_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cur_time   (cur_time),
    .btn_edit   (btn_edit),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_cancel (btn_cancel),
    .time_in    (time_in),
    .set_mil    (set_mil),
    .set_hour   (set_hour),
    .set_minute (set_minute),
    .set_second (set_second),
    .editing    (editing),
    .edit_field (edit_field),
    .edit_val   (edit_val),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge set_mil or posedge set_hour or posedge set_minute or posedge set_second)
    strobe_edges++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input bit e, input bit i, input bit d, input bit c);
    btn_edit = e; btn_inc = i; btn_dec = d; btn_cancel = c;
    @(posedge clk); #1;
    btn_edit = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_load(input logic [31:0] t);
    int mil, h, mn, s;
    mil = int'(t[31:24]); h = int'(t[23:16]); mn = int'(t[15:8]); s = int'(t[7:0]);
    m_f[0] = (mil > 1) ? 1 : mil;
    if (m_f[0] == 1) m_f[1] = (h > 23) ? 0 : h;
    else             m_f[1] = (h < 1 || h > 12) ? 12 : h;
    m_f[2] = (mn > 59) ? 0 : mn;
    m_f[3] = (s > 59) ? 0 : s;
    cf = 0;
  endtask

  task automatic model_step(input bit i, input bit d);
    int lo, hi, old;
    if (i == d) return;
    if (cf == 0)      begin lo = 0; hi = 1; end
    else if (cf == 1) begin lo = (m_f[0] == 1) ? 0 : 1; hi = (m_f[0] == 1) ? 23 : 12; end
    else              begin lo = 0; hi = 59; end
    old = m_f[cf];
    if (i) m_f[cf] = (old == hi) ? lo : old + 1;
    else   m_f[cf] = (old == lo) ? hi : old - 1;
    if (cf == 0 && old == 1 && m_f[0] == 0) begin
      if (m_f[1] == 0)      m_f[1] = 12;
      else if (m_f[1] > 12) m_f[1] = m_f[1] - 12;
    end
  endtask

  task automatic start_edit(input logic [31:0] t);
    cur_time = t;
    press(1, 0, 0, 0);
    model_load(t);
    chk("load_editing", 32'(editing), 1);
    chk("load_field", 32'(edit_field), 0);
    chk("load_val", 32'(edit_val), 32'(m_f[0]));
  endtask

  task automatic advance();
    press(1, 0, 0, 0);
    cf++;
    chk("adv_field", 32'(edit_field), 32'(cf));
    chk("adv_val", 32'(edit_val), 32'(m_f[cf]));
  endtask

  task automatic step(input bit i, input bit d);
    press(0, i, d, 0);
    model_step(i, d);
    chk("step_val", 32'(edit_val), 32'(m_f[cf]));
  endtask

  // Called with the DUT in E_SEC: presses edit and checks the full commit trace.
  task automatic commit(input bit noisy);
    logic [13:0] exp;
    int k, ph;
    int edges0;
    edges0 = strobe_edges;
    press(1, 0, 0, 0);
    for (int c = 1; c <= 13; c++) begin
      if (c <= 12) begin
        k = (c - 1) / 3;
        ph = (c - 1) % 3;
        exp = {1'b1, 1'b0, 4'(ph == 1 ? (4'b1000 >> k) : 4'b0000), 8'(m_f[k])};
      end else begin
        exp = {1'b0, 1'b1, 4'b0000, 8'(m_f[3])};
      end
      chk($sformatf("commit_c%0d", c),
          32'({busy, done, set_mil, set_hour, set_minute, set_second, time_in}), 32'(exp));
      if (noisy) press(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      else tick();
    end
    chk("post_idle", 32'({time_in, done, busy, editing}), 0);
    chk("strobe_count", 32'(strobe_edges - edges0), 4);
  endtask

  initial begin
    vectors = 0; miscompares = 0; strobe_edges = 0;
    btn_edit = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0;
    cur_time = 32'h0;
    rst_n = 0;
    #2;
    chk("reset_outs", 32'({time_in, set_mil, set_hour, set_minute, set_second, editing,
                           edit_field, edit_val, busy, done}), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick();
    chk("idle_outs", 32'({time_in, editing, busy, done, edit_val}), 0);

    // 24h 13:30:45 -> 12h 11:30:45, full commit
    start_edit(32'h010D1E2D);
    chk("dir_mil", 32'(edit_val), 1);
    step(0, 1);
    chk("dir_mil_dec", 32'(edit_val), 0);
    advance();
    chk("dir_hour_remap", 32'(edit_val), 1);
    step(0, 1);
    chk("dir_hour_wrap", 32'(edit_val), 12);
    step(0, 1);
    chk("dir_hour_dec", 32'(edit_val), 11);
    advance();
    advance();
    commit(0);

    // minute wrap at 59, then inc+dec together, then cancel
    start_edit(32'h010D3B2D);
    advance();
    advance();
    chk("dir_min59", 32'(edit_val), 59);
    step(1, 0);
    chk("dir_min_inc_wrap", 32'(edit_val), 0);
    step(0, 1);
    chk("dir_min_dec_wrap", 32'(edit_val), 59);
    step(1, 1);
    chk("dir_min_both", 32'(edit_val), 59);
    press(0, 0, 0, 1);
    chk("dir_cancel_min", 32'(editing), 0);

    // cancel in E_HOUR: no strobes ever
    begin
      int e0;
      e0 = strobe_edges;
      start_edit(32'h010D1E2D);
      advance();
      press(0, 0, 0, 1);
      chk("cancel_hour_editing", 32'({editing, busy}), 0);
      repeat (15) tick();
      chk("cancel_no_strobe", 32'(strobe_edges - e0), 0);
    end

    // same edit as the first session, with buttons pulsed throughout the commit
    start_edit(32'h010D1E2D);
    step(0, 1);
    advance();
    step(0, 1);
    step(0, 1);
    advance();
    advance();
    commit(1);

    // illegal loaded fields
    start_edit(32'h07203C40);
    chk("sanit_mil", 32'(edit_val), 1);
    advance();
    chk("sanit_hour24", 32'(edit_val), 0);
    press(0, 0, 0, 1);
    start_edit(32'h000D1E2D);
    advance();
    chk("sanit_hour12", 32'(edit_val), 12);
    press(0, 0, 0, 1);

    // randomized sessions
    for (int s = 0; s < 25; s++) begin
      logic [31:0] t;
      bit cancelled;
      cancelled = 0;
      t = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 30)),
           8'($urandom_range(0, 66)), 8'($urandom_range(0, 66))};
      start_edit(t);
      for (int f = 0; f < 4 && !cancelled; f++) begin
        int n;
        n = $urandom_range(0, 4);
        for (int j = 0; j < n; j++) begin
          bit i, d;
          i = 1'($urandom);
          d = 1'($urandom);
          if (!i && !d) i = 1;
          step(i, d);
        end
        if ($urandom_range(0, 11) == 0) begin
          press(0, 1'($urandom), 1'($urandom), 1);
          chk("rand_cancel", 32'({editing, busy}), 0);
          cancelled = 1;
        end else if (f < 3) begin
          advance();
        end
      end
      if (!cancelled) commit(s % 2 == 1);
    end

    // async reset during the hour strobe, then reload
    start_edit(32'h01081020);
    advance(); advance(); advance();
    press(1, 0, 0, 0);
    repeat (4) tick();
    chk("rst_pre_hour_pulse", 32'({set_hour, time_in}), 32'({1'b1, 8'h08}));
    #1 rst_n = 0;
    #1;
    chk("rst_async_outs", 32'({time_in, set_mil, set_hour, set_minute, set_second, editing,
                               edit_field, edit_val, busy, done}), 0);
    @(posedge clk); #1;
    chk("rst_held_outs", 32'({time_in, busy, done, editing}), 0);
    rst_n = 1;
    tick();
    chk("rst_idle", 32'({busy, editing}), 0);
    start_edit(32'h00051122);
    chk("rst_reload_mil", 32'(edit_val), 0);
    advance();
    chk("rst_reload_hour", 32'(edit_val), 5);
    press(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
